// File: rtl/alu_seq_if.sv
// -----------------------------------------------------------------------------
// alu_seq_if
//   Operand/result handshake bundle for the sequential ALU.
//
//   Operand side : in_valid, in_ready, op[3:0], a, b
//   Result side  : out_valid, out_ready, result, v (overflow), n (negative),
//                  z (zero)
//
//   master : the producer/consumer around the ALU (drives operands, out_ready)
//   slave  : the ALU itself
//
//   WIDTH must match the WIDTH of the alu_seq instance it is connected to.
// -----------------------------------------------------------------------------
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             v;
    logic             n;
    logic             z;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, v, n, z
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, v, n, z
    );
endinterface

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
//   Handshaked, registered ALU with an iterative shift-add multiplier.
//   Single-cycle ops register their result on the accept edge; MUL spends
//   WIDTH further cycles in BUSY, one shift-add step per cycle.
//
//   Ports
//     clk    : clock, all state on the rising edge
//     rst_n  : asynchronous active-low reset
//     flush  : synchronous abort; forces IDLE, masks out_valid and in_ready
//     bus    : alu_seq_if.slave (operand and result handshakes, flags)
//
//   WIDTH must be a multiple of 8 and at least 8.
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    alu_seq_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int NB  = WIDTH / 8;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_PADDSB = 4'b0010;
    localparam logic [3:0] OP_MUL    = 4'b0011;
    localparam logic [3:0] OP_NAND   = 4'b0100;
    localparam logic [3:0] OP_XOR    = 4'b1000;
    localparam logic [3:0] OP_SLL    = 4'b1100;
    localparam logic [3:0] OP_SRA    = 4'b1101;
    localparam logic [3:0] OP_SRL    = 4'b1110;
    localparam logic [3:0] OP_LLB    = 4'b1010;
    localparam logic [3:0] OP_LHB    = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               v_q, v_d;
    logic               n_q, n_d;
    logic               z_q, z_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]     count_q, count_d;

    logic               in_ready_w;
    logic               accept;
    logic [SHW-1:0]     sh;
    logic [WIDTH-1:0]   sum_w;
    logic [WIDTH-1:0]   diff_w;
    logic [WIDTH-1:0]   padd_res;
    logic [NB-1:0]      padd_sat;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_v;
    logic [2*WIDTH-1:0] acc_step;

    // ------------------------------------------------------------------
    // Handshake outputs. flush masks both sides for the cycle it is high so
    // a producer never believes an ignored operation was taken.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready_w = 1'b0;
        case (state_q)
            IDLE:    in_ready_w = 1'b1;
            DONE:    in_ready_w = bus.out_ready;
            default: in_ready_w = 1'b0;
        endcase
        in_ready_w = in_ready_w & ~flush;
    end

    assign accept        = bus.in_valid & in_ready_w;
    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = (state_q == DONE) & ~flush;
    assign bus.result    = result_q;
    assign bus.v         = v_q;
    assign bus.n         = n_q;
    assign bus.z         = z_q;

    // ------------------------------------------------------------------
    // Per-byte signed saturating add; lanes are independent (no carries).
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NB; gi++) begin : g_padd
        logic [8:0] s9;
        logic       sat_pos;
        logic       sat_neg;
        assign s9      = {bus.a[gi*8+7], bus.a[gi*8 +: 8]} + {bus.b[gi*8+7], bus.b[gi*8 +: 8]};
        // Top two bits of the 9-bit sign-extended sum disagree on overflow.
        assign sat_pos = (s9[8:7] == 2'b01);
        assign sat_neg = (s9[8:7] == 2'b10);
        assign padd_res[gi*8 +: 8] = sat_pos ? 8'h7F : (sat_neg ? 8'h80 : s9[7:0]);
        assign padd_sat[gi]        = sat_pos | sat_neg;
    end

    // ------------------------------------------------------------------
    // Single-cycle datapath.
    // ------------------------------------------------------------------
    assign sh     = bus.b[SHW-1:0];
    assign sum_w  = bus.a + bus.b;
    assign diff_w = bus.a - bus.b;

    always_comb begin
        alu_res = '0;
        alu_v   = 1'b0;
        case (bus.op)
            OP_ADD: begin
                alu_res = sum_w;
                alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_w[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff_w;
                alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff_w[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_PADDSB: begin
                alu_res = padd_res;
                alu_v   = |padd_sat;
            end
            OP_NAND: alu_res = ~(bus.a & bus.b);
            OP_XOR:  alu_res = bus.a ^ bus.b;
            OP_SLL:  alu_res = bus.a << sh;
            OP_SRA:  alu_res = WIDTH'($signed(bus.a) >>> sh);
            OP_SRL:  alu_res = bus.a >> sh;
            OP_LLB:  alu_res = bus.b;
            OP_LHB:  alu_res = {bus.b[WIDTH/2-1:0], bus.a[WIDTH/2-1:0]};
            default: alu_res = '0;
        endcase
    end

    // One shift-add step: multiplicand walks left, multiplier walks right.
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    // ------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        v_d      = v_q;
        n_d      = n_q;
        z_d      = z_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;

        if (flush) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        if (bus.op == OP_MUL) begin
                            state_d  = BUSY;
                            mcand_d  = {{WIDTH{1'b0}}, bus.a};
                            mplier_d = bus.b;
                            acc_d    = '0;
                            count_d  = '0;
                        end else begin
                            state_d  = DONE;
                            result_d = alu_res;
                            v_d      = alu_v;
                            n_d      = alu_res[WIDTH-1];
                            z_d      = ~|alu_res;
                        end
                    end else if (state_q == DONE && bus.out_ready) begin
                        state_d = IDLE;
                    end
                end
                BUSY: begin
                    acc_d    = acc_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + SHW'(1);
                    if (count_q == SHW'(WIDTH - 1)) begin
                        state_d  = DONE;
                        count_d  = '0;
                        result_d = acc_step[WIDTH-1:0];
                        v_d      = |acc_step[2*WIDTH-1:WIDTH];
                        n_d      = acc_step[WIDTH-1];
                        z_d      = ~|acc_step[WIDTH-1:0];
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            v_q      <= 1'b0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            v_q      <= v_d;
            n_q      <= n_d;
            z_q      <= z_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the processor's combinational ALU. It supports a configurable datapath width and adds an iterative multiply. Results and flags are registered, and ready/valid handshakes sit on both the operand side and the result side. It sits between the register-read stage and writeback in the multi-cycle execute path.

## Interface
- WIDTH, 16, datapath width; must be a multiple of 8 and at least 8.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort of any in-flight operation.
- in_valid  in  1  operand/opcode valid.
- in_ready  out  1  block can accept an operation this cycle.
- op  in  4  opcode (see Operation).
- a, b  in  WIDTH each  operands.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes the result this cycle.
- result  out  WIDTH  registered result.
- v, n, z  out  1 each  registered overflow, negative and zero flags.

## Operation
- Opcodes:
  - 0000 ADD: a+b
  - 0001 SUB: a−b
  - 0010 PADDSB: per-byte signed saturating add
  - 0011 MUL: low WIDTH bits of unsigned a*b
  - 0100 NAND: ~(a&b)
  - 1000 XOR: a^b
  - 1100 SLL: a<<b[SHW-1:0]
  - 1101 SRA: arithmetic right shift by b[SHW-1:0]
  - 1110 SRL: logical right shift by b[SHW-1:0]
  - 1010 LLB: result = b
  - 1011 LHB: result = {b[WIDTH/2-1:0], a[WIDTH/2-1:0]}
  - Any other opcode: result 0, flags computed normally.
- Flags (all ops):
  - z = (result == 0).
  - n = result[WIDTH-1].
  - ADD/SUB: v = signed overflow. PADDSB: v = any byte saturated (+127 or −128). MUL: v = upper WIDTH bits of the full product nonzero. All other ops: v = 0.
- FSM:
  - IDLE: in_ready = 1. On accept, a MUL goes to BUSY (loading the multiplicand, the multiplier and a zeroed accumulator, with count = 0). Any other op computes combinationally, registers result and flags, and goes to DONE.
  - BUSY: in_ready = 0. Each cycle performs one shift-add step and increments count. After the WIDTH-th step, registers result and flags and goes to DONE.
  - DONE: out_valid = 1. result, v, n and z hold stable until out_ready = 1. in_ready = out_ready, so a new op can be accepted in the same cycle the old result is taken (back-to-back). If out_ready is high and in_valid is low, go to IDLE.
- flush = 1: next state is IDLE, out_valid = 0, any BUSY count is discarded and in_valid is ignored that cycle. flush takes priority over every other event.
- Arithmetic is modulo 2^WIDTH except PADDSB. PADDSB has no inter-byte carries.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, out_valid = 0, result = 0, v = n = z = 0, count = 0. in_ready = 1 once rst_n is released.
- Latency, counted from the accept edge (in_valid & in_ready) to the first cycle of out_valid:
  - Single-cycle ops: 1 cycle.
  - MUL: WIDTH+1 cycles.
- Throughput:
  - Single-cycle ops: 1 op per cycle while out_ready is held high.
  - MUL: 1 op per WIDTH+1 cycles.
- Outputs are registered only; no combinational path from a, b or op to result or flags. in_ready depends combinationally on out_ready in DONE only.
- Stall: with out_valid = 1 and out_ready = 0, result and flags stay constant indefinitely and no new op is accepted.
- Reset asserted mid-MUL: immediate return to IDLE. Outputs go to their reset values with no partial result visible.

## Test plan
- Reset, then ADD a=0x7FFF, b=0x0001 with out_ready = 1 -> one cycle later result 0x8000, v=1, n=1, z=0. SUB a=0x1234, b=0x1234 -> result 0x0000, z=1, v=0.
- PADDSB a=0x7F80, b=0x01FF -> result 0x7F80, v=1. With WIDTH=32, LHB a=0xAAAA5555, b=0x0000BEEF -> result 0xBEEF5555.
- MUL a=0x0123, b=0x0045 (WIDTH=16) -> out_valid exactly 17 cycles after accept, result 0x4E6F, v=0. MUL 0xFFFF*0x0002 -> result 0xFFFE, v=1.
- Back-to-back XOR, SRA, SRL streamed with out_ready held high -> one result per cycle. SRA 0x8000 by 4 -> 0xF800. SRL 0x8000 by 4 -> 0x0800.
- out_ready held low for 5 cycles after NAND 0xFFFF, 0xFFFF -> result 0x0000 and z=1 stable, in_ready = 0 throughout. Release -> new op accepted in the same cycle.
- flush at cycle 8 of a MUL -> IDLE next cycle, out_valid never asserts. A following ADD completes normally. rst_n pulsed low mid-MUL -> all outputs return to reset values asynchronously.
